// File: rtl/circular_fifo.sv
// circular_fifo: single-clock circular-buffer FIFO with first-word fall-through and full/empty flags.
// Define CIRC_FIFO_ERR_FLAGS_EN to build the registered overflow_o/underflow_o pulses and their warnings.
module circular_fifo #(
    parameter int DATA_W       = 1,
    parameter int FIFO_DEPTH_W = 2,
    parameter int ID           = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o,
    output logic              underflow_o
);
    localparam int DEPTH = 1 << FIFO_DEPTH_W;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [FIFO_DEPTH_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  wr_ok, rd_ok;
    logic                  unused_id;

    assign unused_id = ID[0];

    assign empty_o = wr_ptr_q == rd_ptr_q;
    assign full_o  = (wr_ptr_q[FIFO_DEPTH_W-1:0] == rd_ptr_q[FIFO_DEPTH_W-1:0]) &&
                     (wr_ptr_q[FIFO_DEPTH_W] != rd_ptr_q[FIFO_DEPTH_W]);
    assign data_o  = mem_q[rd_ptr_q[FIFO_DEPTH_W-1:0]];

    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it
    assign wr_ok    = wr_en_i && (!full_o || rd_en_i);
    assign rd_ok    = rd_en_i && !empty_o;
    assign wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (wr_ok) mem_q[wr_ptr_q[FIFO_DEPTH_W-1:0]] <= data_i;
        end
    end

`ifdef CIRC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    assign overflow_d  = wr_en_i && full_o && !rd_en_i;
    assign underflow_d = rd_en_i && empty_o;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni && overflow_d)  $display("circular_fifo[%0d]: write rejected, FIFO full", ID);
        if (rst_ni && underflow_d) $display("circular_fifo[%0d]: read rejected, FIFO empty", ID);
    end
`endif
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_circular_fifo.sv
// tb_circular_fifo: directed and random stimulus against a queue-based FIFO reference model.
module tb_circular_fifo;
    logic       clk = 1'b0, rst_n = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [7:0] din = '0, dout;
    logic       full, empty, ovf, unf;
    int         tests = 0, fails = 0;
    logic [7:0] q[$];
    bit         ovf_e, unf_e;

`ifdef CIRC_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    circular_fifo #(.DATA_W(8), .FIFO_DEPTH_W(2), .ID(3)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr), .rd_en_i(rd), .data_i(din),
        .data_o(dout), .full_o(full), .empty_o(empty), .overflow_o(ovf), .underflow_o(unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == 4));
        if (q.size() > 0) chk({tag, ".data"}, 32'(dout), 32'(q[0]));
        chk({tag, ".overflow"}, 32'(ovf), 32'(ovf_e));
        chk({tag, ".underflow"}, 32'(unf), 32'(unf_e));
    endtask

    // Called at a falling edge: apply request, check outputs, advance the model over one rising edge
    task automatic step(input string tag, input bit w, input bit r, input logic [7:0] d);
        bit acc_w, acc_r;
        wr = w; rd = r; din = d;
        #1;
        check_state(tag);
        acc_w = w && (q.size() < 4 || r);
        acc_r = r && q.size() > 0;
        ovf_e = ERR_EN && w && q.size() == 4 && !r;
        unf_e = ERR_EN && r && q.size() == 0;
        @(posedge clk);
        if (acc_r) void'(q.pop_front());
        if (acc_w) q.push_back(d);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        q.delete();
        ovf_e = 0;
        unf_e = 0;
        check_state(tag);
        chk({tag, ".data0"}, 32'(dout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset("reset");
        for (int i = 0; i < 4; i++) step("fill", 1, 0, 8'(8'h11 * (i + 1)));
        for (int i = 0; i < 4; i++) step("drain", 0, 1, 8'h00);
        step("empty_idle", 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step("refill", 1, 0, 8'(8'h11 * (i + 1)));
        step("overflow_req", 1, 0, 8'h55);
        step("overflow_pulse", 0, 0, 8'h00);
        step("overflow_gone", 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step("drain_after_ovf", 0, 1, 8'h00);
        step("underflow_req", 0, 1, 8'h00);
        step("underflow_pulse", 0, 0, 8'h00);
        step("underflow_gone", 0, 0, 8'h00);
        step("empty_wr_rd", 1, 1, 8'h77);
        step("one_entry", 0, 1, 8'h00);
        for (int i = 0; i < 4; i++) step("fill2", 1, 0, 8'(8'h11 * (i + 1)));
        step("full_wr_rd", 1, 1, 8'h66);
        for (int i = 0; i < 4; i++) step("drain_66", 0, 1, 8'h00);
        step("drained", 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step("wrap_wr", 1, 0, 8'(8'hA0 + i));
            step("wrap_rd", 0, 1, 8'h00);
        end
        step("wrap_end", 1, 0, 8'hBB);
        step("pre_reset", 1, 0, 8'hCC);
        do_reset("mid_reset");
        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset("rand_reset");
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        step("final", 0, 0, 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/circular_fifo.md
# circular_fifo

Single-clock circular-buffer FIFO, parameterized width and power-of-two depth. Used as the synchronous buffer wherever producer and consumer share one clock, e.g. the buffer-throughput bench when read and write periods are equal. Provides full/empty status for ready/valid-style flow control and optional overflow/underflow error pulses.

## Interface
- DATA_W, 1, data word width in bits (≥1)
- FIFO_DEPTH_W, 2, log2 of depth; DEPTH = 2**FIFO_DEPTH_W entries (≥1)
- ID, 0, instance tag; no hardware effect, printed in simulation error messages
- clk_i  input  1  clock, all logic on rising edge
- rst_ni  input  1  reset, asynchronous assert, active-low
- wr_en_i  input  1  write request
- rd_en_i  input  1  read request (pop)
- data_i  input  DATA_W  write data
- data_o  output  DATA_W  head-of-queue data
- full_o  output  1  FIFO holds DEPTH entries
- empty_o  output  1  FIFO holds 0 entries
- overflow_o  output  1  pulse: rejected write
- underflow_o  output  1  pulse: rejected read

## Operation
- Storage: DEPTH×DATA_W register array; write pointer wr_ptr and read pointer rd_ptr, each FIFO_DEPTH_W+1 bits (extra wrap bit).
- Index = pointer low FIFO_DEPTH_W bits; pointers increment modulo 2**(FIFO_DEPTH_W+1).
- empty_o = (wr_ptr == rd_ptr); full_o = (low bits equal) && (wrap bits differ). Both combinational from registered pointers.
- Write accepted when wr_en_i && (!full_o || rd_en_i): mem[wr_ptr] <= data_i, wr_ptr++.
- Read accepted when rd_en_i && !empty_o: rd_ptr++.
- Full + simultaneous write and read: both accepted, stays full, no overflow.
- Empty + simultaneous write and read: write accepted, read rejected (underflow), next cycle holds 1 entry.
- Rejected write (wr_en_i && full_o && !rd_en_i): data dropped, pointers unchanged.
- Rejected read (rd_en_i && empty_o): pointers unchanged.
- data_o = mem[rd_ptr index], combinational (first-word fall-through); valid whenever empty_o=0; while empty shows stale array content.

## Timing
- Reset (rst_ni=0, asynchronous): wr_ptr=rd_ptr=0, all memory entries 0, empty_o=1, full_o=0, overflow_o=0, underflow_o=0, data_o=0.
- Reset mid-operation discards all contents immediately; deassertion takes effect at next rising edge.
- Write latency: data written at edge N visible on data_o after edge N if it is the head; empty_o falls after edge N.
- Read: data_o valid in same cycle as rd_en_i; next entry appears after the edge.
- full_o rises after the edge accepting the DEPTH-th entry; falls after the edge of the first accepted read.
- overflow_o/underflow_o: registered, high for exactly one cycle after the edge where the rejected request was sampled.

## Configuration
- Macro CIRC_FIFO_ERR_FLAGS_EN.
- Defined: overflow_o/underflow_o registers implemented as above; simulation $display warning with ID on each rejected request.
- Undefined: overflow_o and underflow_o tied to 0, no registers, no messages; FIFO data/flag behaviour unchanged.

## Test plan
(FIFO_DEPTH_W=2, DATA_W=8, macro defined)
- Reset -> empty_o=1, full_o=0, data_o=0, overflow_o=underflow_o=0.
- Write 0x11,0x22,0x33,0x44 on 4 consecutive cycles -> full_o=1 after 4th edge; data_o=0x11; then read 4 cycles -> data_o 0x11,0x22,0x33,0x44, empty_o=1 after last.
- Full, write 0x55 without read -> overflow_o=1 one cycle, contents unchanged, reads return 0x11..0x44.
- Empty, rd_en_i=1 -> underflow_o=1 one cycle, pointers unchanged, empty_o stays 1.
- Full, wr_en_i=rd_en_i=1 with 0x66 -> full_o stays 1, no overflow; drain order 0x22,0x33,0x44,0x66.
- 10 writes/10 reads interleaved 1:1 across pointer wrap -> data order preserved, full_o never 1, no error pulses; assert rst_ni mid-stream -> empty_o=1 immediately.
